// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB-first, parity, stop(1).
// Rebuilds the word, checks XOR parity and flags framing errors; all outputs registered.
module parity_frame_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              acc;
    logic              perr_int;

    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!rx_bit) state_nxt = DATA;
                DATA:    if (cnt == CNT_W'(DATA_W - 1)) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                // A low stop bit is never reused as the next start bit.
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            perr_int   <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        acc <= 1'b0;
                    end
                    DATA: begin
                        shreg <= {rx_bit, shreg[DATA_W-1:1]};
                        acc   <= acc ^ rx_bit;
                        cnt   <= cnt + CNT_W'(1);
                    end
                    PARITY: perr_int <= acc ^ rx_bit ^ PARITY_ODD;
                    STOP: begin
                        if (rx_bit) begin
                            data       <= shreg;
                            data_valid <= 1'b1;
                            parity_err <= perr_int;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
